slow_clock_receiver: RTL
========================

Name: slow_clock_receiver

Overview:
- Receiving end of the team's divided game clocks: accepts a slow, square-wave clock-like level produced by a divider, possibly from another clock domain.
- Synchronizes the level into the fast system clock and emits single-cycle rise/fall enable pulses, so downstream logic (sprite movement, game step) runs on clk with enables instead of on derived clocks.
- Also measures the slow period, counts game steps and flags a stalled or lost source.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth (minimum 2).
- CNT_W, 32, width of the period and watchdog counters.
- TIMEOUT, 100000000, fast cycles without any edge before stall is declared.
- STEP_W, 16, width of the game-step counter.
- FILT, 4, glitch-filter stability length in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- slow_in  in  1  divided clock level, asynchronous to clk.
- step_en  in  1  when 1, rise pulses advance step_cnt.
- rise_tick  out  1  one-cycle pulse per accepted rising edge.
- fall_tick  out  1  one-cycle pulse per accepted falling edge.
- period_out  out  CNT_W  clk cycles between the last two accepted rising edges.
- period_valid  out  1  period_out holds a genuine measurement.
- step_cnt  out  STEP_W  game-step counter.
- stalled  out  1  no edge for TIMEOUT cycles.

Behaviour:
- Reset (rst=0, async): all sync flops, the previous-level flop, counters and outputs go to 0; FSM goes to IDLE. A reset mid-measurement discards everything, with no partial period reported.
- Synchronizer: SYNC_STAGES flops in series; s is the last stage. The previous-level register p samples s every cycle.
- Edges: rise = s & ~p; fall = ~s & p. rise_tick/fall_tick are registered and are 1 for exactly one cycle. Latency from the slow_in transition to the tick is SYNC_STAGES+1 clk edges.
- Period counter:
  - Increments every cycle and saturates at 2^CNT_W-1.
  - On rise: period_out <= counter+1 (saturating); counter <= 0.
- Watchdog: increments every cycle and clears on any rise or fall. Reaching TIMEOUT drives the FSM to STALLED.
- FSM states:
  - IDLE: no rise seen. Rise goes to ARMED; period_out is not updated and period_valid stays 0.
  - ARMED: one rise seen. Rise updates period_out, sets period_valid=1 and goes to LOCKED.
  - LOCKED: each rise updates period_out with period_valid held at 1.
  - STALLED: stalled=1, period_valid=0, period_out holds its last value. Any edge clears stalled and goes to ARMED if it is a rise, IDLE if it is a fall. The period counter restarts at 0 on that edge.
  - From IDLE, ARMED or LOCKED: watchdog==TIMEOUT goes to STALLED.
- Simultaneous events:
  - An edge in the same cycle as the watchdog reaching TIMEOUT: the edge wins and no stall is declared.
  - A rise with step_en=1 increments step_cnt in the same cycle the rise_tick register is set. step_cnt wraps from 2^STEP_W-1 to 0.
- step_en: ignored on fall. When step_en=0, the rise is still reported and measured.
- Ticks and the period measurement stay active in all states, including STALLED.

Optional Feature:
- Macro: SLOW_CLOCK_RECEIVER_GLITCH_FILTER_EN.
- Defined:
  - A FILT-cycle stability filter sits between s and p.
  - The filtered level changes only after s has differed from it for FILT consecutive cycles; any bounce restarts the count.
  - Edge detection uses the filtered level, so latency grows by FILT cycles.
  - Pulses on slow_in shorter than FILT cycles produce no tick.
- Undefined: no filter; s feeds edge detection directly and the FILT parameter is unused.

Test Plan:
- Reset behaviour: assert rst=0 mid-run with slow_in toggling -> all outputs 0 immediately (asynchronously). After rst=1, the first rise gives rise_tick with period_valid=0 and state ARMED.
- Measurement and latency: slow_in toggles every 5 clk (period 10), SYNC_STAGES=2 -> rise_tick is a 1-cycle pulse 3 edges after each slow_in rise. After the 2nd rise, period_out=10 and period_valid=1; it stays 10 while the input is steady.
- Stall and recovery: TIMEOUT=32, slow_in held at 1 after locking -> stalled=1 and period_valid=0 exactly 32 cycles after the last edge. The next fall gives stalled=0 and state IDLE; two later rises 10 apart give period_out=10, period_valid=1.
- Step counter: STEP_W=4, step_en=1, 17 rises -> step_cnt=1 (wrapped). With step_en=0, rises produce rise_tick but step_cnt is unchanged.
- Edge/timeout collision: an edge arriving in the exact cycle the watchdog hits TIMEOUT -> stalled stays 0 and a tick is produced.
- Glitch filter (with macro, FILT=4): 2-cycle high glitch on slow_in -> no rise_tick. A clean transition gives rise_tick at SYNC_STAGES+FILT+1 edges.

Source files
------------

// File: rtl/slow_clock_receiver.sv
// Receives a divided slow clock level, synchronizes it into clk and turns it into rise/fall enables,
// plus period measurement, game-step counting and stall detection. Glitch filter: SLOW_CLOCK_RECEIVER_GLITCH_FILTER_EN.

// state      | meaning
// ST_IDLE    | no rising edge seen since reset or since a fall ended a stall
// ST_ARMED   | one rising edge seen, period counter running from it
// ST_LOCKED  | period_out holds a genuine rise-to-rise measurement
// ST_STALLED | no edge for TIMEOUT cycles, period_out frozen
module slow_clock_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 100000000,
  parameter int STEP_W      = 16,
  parameter int FILT        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_in,
  input  logic              step_en,
  output logic              rise_tick,
  output logic              fall_tick,
  output logic [CNT_W-1:0]  period_out,
  output logic              period_valid,
  output logic [STEP_W-1:0] step_cnt,
  output logic              stalled
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_STALLED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("slow_clock_receiver: SYNC_STAGES must be at least 2");
  end
  if (FILT < 1) begin : g_chk_filt
    $error("slow_clock_receiver: FILT must be at least 1");
  end

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   lvl;
  logic                   lvl_q;
  logic                   rise;
  logic                   fall;
  logic                   edge_any;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_sat;
  logic [CNT_W-1:0]       wd;
  logic                   wd_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef SLOW_CLOCK_RECEIVER_GLITCH_FILTER_EN
  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [FW-1:0] filt_cnt;

  // lvl follows s only once s has disagreed with it for FILT consecutive cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl      <= 1'b0;
      filt_cnt <= '0;
    end else if (s == lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT - 1)) begin
      lvl      <= s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
`else
  assign lvl = s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl;
    end
  end

  assign rise     = lvl & ~lvl_q;
  assign fall     = ~lvl & lvl_q;
  assign edge_any = rise | fall;
  assign cnt_sat  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign wd_hit   = (wd == WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // an edge always beats a simultaneous watchdog expiry
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rise) state_nxt = ST_ARMED;
        else if (!edge_any && wd_hit) state_nxt = ST_STALLED;
      end
      ST_ARMED: begin
        if (rise) state_nxt = ST_LOCKED;
        else if (!edge_any && wd_hit) state_nxt = ST_STALLED;
      end
      ST_LOCKED: begin
        if (!edge_any && wd_hit) state_nxt = ST_STALLED;
      end
      ST_STALLED: begin
        if (rise) state_nxt = ST_ARMED;
        else if (fall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stalled      = (state == ST_STALLED);
    period_valid = (state == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      cnt        <= '0;
      period_out <= '0;
      wd         <= '0;
      step_cnt   <= '0;
    end else begin
      rise_tick <= rise;
      fall_tick <= fall;

      if (rise || (state == ST_STALLED && fall)) cnt <= '0;
      else cnt <= cnt_sat;

      // the first rise after IDLE/STALLED only starts the counter
      if (rise && (state == ST_ARMED || state == ST_LOCKED)) period_out <= cnt_sat;

      if (edge_any) wd <= '0;
      else if (!wd_hit) wd <= wd + 1'b1;

      if (rise && step_en) step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule
